// File: rtl/input_conditioner.sv
// Conditions a bouncy step button plus data/mode switches into a clean
// sig_to_test/ena stream, with a hands-free auto mode that plays PATTERN MSB-first.
module input_conditioner #(
  parameter int                     DEBOUNCE_CYCLES = 500000,
  parameter int                     AUTO_DIV        = 25000000,
  parameter int                     PATTERN_LEN     = 16,
  parameter logic [PATTERN_LEN-1:0] PATTERN         = 16'h4925
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_step,
  input  logic                           sw_data,
  input  logic                           sw_auto,
  output logic                           sig_to_test,
  output logic                           ena,
  output logic [$clog2(PATTERN_LEN)-1:0] bit_idx,
  output logic                           auto_active
);

  localparam int IDX_W = $clog2(PATTERN_LEN);
  localparam int DIV_W = $clog2(AUTO_DIV);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(AUTO_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_LEN - 1);

  typedef enum logic [1:0] {MANUAL, AUTO_RUN, AUTO_PAUSE} state_e;

  // Bit order inside every per-input vector: 0 = btn_step, 1 = sw_data, 2 = sw_auto.
  logic [2:0]       sync1, sync2, deb;
  logic [CNT_W-1:0] db_cnt [3];
  logic             btn_q;
  logic             step_evt;
  logic             data_db, auto_db;

  state_e           state, next_state;
  logic [DIV_W-1:0] div;
  logic             div_tc;
  logic             ena_d, sig_d;

  assign data_db  = deb[1];
  assign auto_db  = deb[2];
  assign step_evt = deb[0] & ~btn_q;
  assign div_tc   = (div == DIV_MAX);

  // NOTE: the counter array is reset explicitly; it is control state, not storage,
  // and a stale count after reset would shorten the first debounce window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      btn_q <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {sw_auto, sw_data, btn_step};
      sync2 <= sync1;
      btn_q <= deb[0];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MANUAL;
    else      state <= next_state;
  end

  // Leaving auto mode outranks a same-cycle step event.
  always_comb begin
    next_state = state;
    unique case (state)
      MANUAL:     if (auto_db)       next_state = AUTO_RUN;
      AUTO_RUN:   if (!auto_db)      next_state = MANUAL;
                  else if (step_evt) next_state = AUTO_PAUSE;
      AUTO_PAUSE: if (!auto_db)      next_state = MANUAL;
                  else if (step_evt) next_state = AUTO_RUN;
      default:                       next_state = MANUAL;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ena_d       = 1'b0;
    sig_d       = sig_to_test;
    auto_active = (state != MANUAL);
    unique case (state)
      MANUAL: if (step_evt) begin
        ena_d = 1'b1;
        sig_d = data_db;
      end
      AUTO_RUN: if (div_tc && next_state == AUTO_RUN) begin
        ena_d = 1'b1;
        sig_d = PATTERN[bit_idx];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ena         <= 1'b0;
      sig_to_test <= 1'b0;
      bit_idx     <= IDX_LAST;
      div         <= '0;
    end else begin
      ena         <= ena_d;
      sig_to_test <= sig_d;
      if (next_state == AUTO_RUN && state != AUTO_RUN) begin
        div <= '0;
        if (state == MANUAL) bit_idx <= IDX_LAST;
      end else if (state == AUTO_RUN && next_state == AUTO_RUN) begin
        if (div_tc) begin
          div     <= '0;
          bit_idx <= (bit_idx == '0) ? IDX_LAST : bit_idx - 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule
